// File: rtl/iiitb_tlc_pkg.sv
// Shared definitions for the traffic light controller and its sensor conditioning stage.
// State encoding and default timing constants live here so both blocks agree.
package iiitb_tlc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2,
    STUCK  = 2'd3
  } sensor_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int HOLD_CYCLES_DEF     = 32;
  localparam int STUCK_CYCLES_DEF    = 1024;
  localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/iiitb_tlc_debounce.sv
// Two-flop synchroniser for the raw loop detector followed by a consecutive-mismatch debounce.
// filt only toggles after DEBOUNCE_CYCLES back-to-back cycles that disagree with it.
module iiitb_tlc_debounce
  import iiitb_tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic loop_raw,
  output logic filt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [DW-1:0] db_cnt_q;
  logic [DW-1:0] db_cnt_d;

  // Any agreeing cycle restarts the count, so only an unbroken run of mismatches flips filt.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == DB_LAST) begin
        filt_d = ~filt_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= loop_raw;
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/iiitb_tlc_sensor_cond.sv
// Vehicle-detector conditioning stage feeding the controller's sensor input: debounce,
// minimum hold after a detection, saturating vehicle count and stuck-detector lockout.
module iiitb_tlc_sensor_cond
  import iiitb_tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_raw,
  input  logic             clear_cnt,
  output logic             sensor,
  output logic [CNT_W-1:0] vehicle_cnt,
  output logic             stuck
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

  logic             filt;
  logic             filt_prev_q;
  logic             filt_rise;
  logic             filt_fall;
  sensor_state_e    state_q;
  sensor_state_e    state_d;
  logic [HW-1:0]    hold_q;
  logic [HW-1:0]    hold_d;
  logic [SW-1:0]    stuck_cnt_q;
  logic [SW-1:0]    stuck_cnt_d;
  logic [CNT_W-1:0] veh_q;
  logic [CNT_W-1:0] veh_d;

  iiitb_tlc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .loop_raw (loop_raw),
    .filt     (filt)
  );

  assign filt_rise = filt & ~filt_prev_q;
  assign filt_fall = ~filt & filt_prev_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    stuck_cnt_d = stuck_cnt_q;
    case (state_q)
      IDLE: begin
        if (filt_rise) begin
          state_d     = ACTIVE;
          stuck_cnt_d = '0;
        end
      end
      ACTIVE: begin
        // A fall on the same cycle the stuck limit is hit still gets the normal hold.
        if (filt_fall) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end else begin
          stuck_cnt_d = stuck_cnt_q + 1'b1;
          if (stuck_cnt_q == STUCK_LAST) begin
            state_d = STUCK;
          end
        end
      end
      HOLD: begin
        if (filt_rise) begin
          state_d     = ACTIVE;
          stuck_cnt_d = '0;
          hold_d      = '0;
        end else if (hold_q <= HW'(1)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      STUCK: begin
        if (filt_fall) begin
          state_d     = IDLE;
          stuck_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear beats a same-cycle rise; the count sticks at all-ones.
  always_comb begin
    veh_d = veh_q;
    if (clear_cnt) begin
      veh_d = '0;
    end else if (filt_rise && (veh_q != '1)) begin
      veh_d = veh_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_prev_q <= 1'b0;
      state_q     <= IDLE;
      hold_q      <= '0;
      stuck_cnt_q <= '0;
      veh_q       <= '0;
    end else begin
      filt_prev_q <= filt;
      state_q     <= state_d;
      hold_q      <= hold_d;
      stuck_cnt_q <= stuck_cnt_d;
      veh_q       <= veh_d;
    end
  end

  assign sensor      = (state_q == ACTIVE) || (state_q == HOLD);
  assign stuck       = (state_q == STUCK);
  assign vehicle_cnt = veh_q;

endmodule

// File: tb/tb_iiitb_tlc_sensor_cond.sv
// Bench for the sensor conditioning stage: directed scenarios plus random loop activity,
// checked against an event-timestamp model of the filtered detector.
module tb_iiitb_tlc_sensor_cond;
  import iiitb_tlc_pkg::*;

  localparam int DEB     = 8;
  localparam int HLD     = 32;
  localparam int STK     = 1024;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          loop_raw  = 1'b0;
  logic          clear_cnt = 1'b0;
  logic          sensor;
  logic          stuck;
  logic [CW-1:0] vehicle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  iiitb_tlc_sensor_cond #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HLD),
    .STUCK_CYCLES   (STK),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .loop_raw    (loop_raw),
    .clear_cnt   (clear_cnt),
    .sensor      (sensor),
    .vehicle_cnt (vehicle_cnt),
    .stuck       (stuck)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // filt flips once the last DEB synchronised samples all disagree with it; the outputs
  // follow from the edge times of filt rises/falls.
  logic   m_raw1 = 1'b0, m_raw2 = 1'b0;
  logic   m_filt = 1'b0, m_filt_prev = 1'b0;
  logic   m_fell_stuck = 1'b0;
  int     m_win[$];
  longint m_n = 0;
  longint m_t_rise = -1000000;
  longint m_t_fall = -1000000;
  int     m_cnt = 0;
  logic   exp_sensor = 1'b0;
  logic   exp_stuck  = 1'b0;

  function automatic void model_reset();
    m_raw1 = 1'b0; m_raw2 = 1'b0;
    m_filt = 1'b0; m_filt_prev = 1'b0;
    m_fell_stuck = 1'b0;
    m_win.delete();
    m_n = 0;
    m_t_rise = -1000000;
    m_t_fall = -1000000;
    m_cnt = 0;
    exp_sensor = 1'b0;
    exp_stuck  = 1'b0;
  endfunction

  function automatic void model_step();
    logic new_filt;
    bit   all_diff;
    m_win.push_back(int'(m_raw2));
    if (m_win.size() > DEB) void'(m_win.pop_front());
    new_filt = m_filt;
    if (m_win.size() == DEB) begin
      all_diff = 1'b1;
      foreach (m_win[i]) if (m_win[i] == int'(m_filt)) all_diff = 1'b0;
      if (all_diff) new_filt = ~m_filt;
    end
    if (m_filt && !m_filt_prev) m_t_rise = m_n;
    if (!m_filt && m_filt_prev) begin
      m_t_fall     = m_n;
      m_fell_stuck = (m_n - m_t_rise) > STK;
    end
    if (clear_cnt) m_cnt = 0;
    else if (m_filt && !m_filt_prev && m_cnt < CNT_MAX) m_cnt++;
    exp_stuck  = m_filt && ((m_n - m_t_rise) >= STK);
    exp_sensor = m_filt ? !exp_stuck : (!m_fell_stuck && ((m_n - m_t_fall) < HLD));
    m_filt_prev = m_filt;
    m_filt      = new_filt;
    m_raw2      = m_raw1;
    m_raw1      = loop_raw;
    m_n++;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- driver ----------------
  task automatic step(input logic raw, input logic clr);
    loop_raw  = raw;
    clear_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (sensor !== 1'b0 || stuck !== 1'b0 || vehicle_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset step %0d: sensor/stuck/cnt=%b/%b/%0d expected 0/0/0",
                 i, sensor, stuck, vehicle_cnt);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (sensor !== exp_sensor || stuck !== exp_stuck || vehicle_cnt !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL reset_release step %0d: sensor/stuck/cnt=%b/%b/%0d expected %b/%b/%0d",
                 i, sensor, stuck, vehicle_cnt, exp_sensor, exp_stuck, m_cnt);
      end
    end
  endtask

  task automatic test_glitch();
    int cnt_before;
    cnt_before = m_cnt;
    for (int i = 0; i < 45; i++) begin
      step(i < 5, 1'b0);
      n_checks++;
      if (sensor !== 1'b0 || vehicle_cnt !== CW'(cnt_before)) begin
        n_fail++;
        $display("FAIL glitch_pulse step %0d: sensor/cnt=%b/%0d expected 0/%0d",
                 i, sensor, vehicle_cnt, cnt_before);
      end
    end
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    cnt_before = m_cnt;
    for (int i = 0; i < 35; i++) begin
      step(i >= 5, 1'b0);
      n_checks++;
      if (sensor !== 1'b1 || vehicle_cnt !== CW'(cnt_before)) begin
        n_fail++;
        $display("FAIL glitch_gap step %0d: sensor/cnt=%b/%0d expected 1/%0d",
                 i, sensor, vehicle_cnt, cnt_before);
      end
    end
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (sensor !== exp_sensor || stuck !== exp_stuck || vehicle_cnt !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL glitch_tail step %0d: sensor/stuck/cnt=%b/%b/%0d expected %b/%b/%0d",
                 i, sensor, stuck, vehicle_cnt, exp_sensor, exp_stuck, m_cnt);
      end
    end
  endtask

  task automatic test_clean_vehicle();
    int rise_idx = -1;
    int fall_idx = -1;
    step(1'b0, 1'b1);
    n_checks++;
    if (vehicle_cnt !== '0) begin
      n_fail++;
      $display("FAIL clean_clear: cnt=%0d expected 0", vehicle_cnt);
    end
    for (int i = 0; i < 80; i++) begin
      step(i < 20, 1'b0);
      if (rise_idx < 0 && sensor === 1'b1) rise_idx = i;
      if (rise_idx >= 0 && fall_idx < 0 && sensor === 1'b0) fall_idx = i;
      n_checks++;
      if (sensor !== exp_sensor || stuck !== exp_stuck || vehicle_cnt !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL clean_model step %0d: sensor/stuck/cnt=%b/%b/%0d expected %b/%b/%0d",
                 i, sensor, stuck, vehicle_cnt, exp_sensor, exp_stuck, m_cnt);
      end
    end
    n_checks++;
    if (rise_idx != DEB + 2) begin
      n_fail++;
      $display("FAIL clean_rise_latency: got %0d expected %0d", rise_idx, DEB + 2);
    end
    n_checks++;
    if (fall_idx != 20 + DEB + HLD + 2) begin
      n_fail++;
      $display("FAIL clean_fall_latency: got %0d expected %0d", fall_idx, 20 + DEB + HLD + 2);
    end
    n_checks++;
    if (vehicle_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL clean_count: cnt=%0d expected 1", vehicle_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int rise_idx = -1;
    int fall_idx = -1;
    step(1'b0, 1'b1);
    for (int i = 0; i < 140; i++) begin
      step((i < 20) || (i >= 35 && i < 55), 1'b0);
      if (rise_idx < 0 && sensor === 1'b1) rise_idx = i;
      if (rise_idx >= 0 && fall_idx < 0 && sensor === 1'b0) fall_idx = i;
      n_checks++;
      if (sensor !== exp_sensor || stuck !== exp_stuck || vehicle_cnt !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL retrig_model step %0d: sensor/stuck/cnt=%b/%b/%0d expected %b/%b/%0d",
                 i, sensor, stuck, vehicle_cnt, exp_sensor, exp_stuck, m_cnt);
      end
    end
    n_checks++;
    if (rise_idx != DEB + 2 || fall_idx != 55 + DEB + HLD + 2) begin
      n_fail++;
      $display("FAIL retrig_continuous: high from %0d to %0d expected %0d to %0d",
               rise_idx, fall_idx, DEB + 2, 55 + DEB + HLD + 2);
    end
    n_checks++;
    if (vehicle_cnt !== CW'(2)) begin
      n_fail++;
      $display("FAIL retrig_count: cnt=%0d expected 2", vehicle_cnt);
    end
  endtask

  task automatic test_stuck();
    int stuck_idx = -1;
    int clear_idx = -1;
    int sensor_after = 0;
    logic sensor_at_stuck = 1'bx;
    for (int i = 0; i < 1180; i++) begin
      step(i < 1100, 1'b0);
      if (stuck_idx < 0 && stuck === 1'b1) begin
        stuck_idx = i;
        sensor_at_stuck = sensor;
      end
      if (stuck_idx >= 0 && clear_idx < 0 && stuck === 1'b0) clear_idx = i;
      if (stuck_idx >= 0 && sensor !== 1'b0) sensor_after++;
      n_checks++;
      if (sensor !== exp_sensor || stuck !== exp_stuck || vehicle_cnt !== CW'(m_cnt)) begin
        n_fail++;
        $display("FAIL stuck_model step %0d: sensor/stuck/cnt=%b/%b/%0d expected %b/%b/%0d",
                 i, sensor, stuck, vehicle_cnt, exp_sensor, exp_stuck, m_cnt);
      end
    end
    n_checks++;
    if (stuck_idx != DEB + 2 + STK || sensor_at_stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_entry: at %0d sensor=%b expected at %0d sensor=0",
               stuck_idx, sensor_at_stuck, DEB + 2 + STK);
    end
    n_checks++;
    if (clear_idx != 1100 + DEB + 2) begin
      n_fail++;
      $display("FAIL stuck_exit: got %0d expected %0d", clear_idx, 1100 + DEB + 2);
    end
    n_checks++;
    if (sensor_after != 0) begin
      n_fail++;
      $display("FAIL stuck_no_hold: sensor high %0d cycles after lockout expected 0", sensor_after);
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 1'b1);
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 80; i++) begin
        step(i < 20, 1'b0);
        n_checks++;
        if (sensor !== exp_sensor || stuck !== exp_stuck || vehicle_cnt !== CW'(m_cnt)) begin
          n_fail++;
          $display("FAIL sat_model veh %0d step %0d: sensor/stuck/cnt=%b/%b/%0d expected %b/%b/%0d",
                   v, i, sensor, stuck, vehicle_cnt, exp_sensor, exp_stuck, m_cnt);
        end
      end
    end
    n_checks++;
    if (vehicle_cnt !== CW'(CNT_MAX)) begin
      n_fail++;
      $display("FAIL sat_count: cnt=%0d expected %0d", vehicle_cnt, CNT_MAX);
    end
  endtask

  task automatic test_clear_and_reset();
    for (int i = 0; i < 40; i++) begin
      step(i < 20, i == DEB + 2);
      if (i == DEB + 2) begin
        n_checks++;
        if (vehicle_cnt !== '0 || sensor !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_coincident: sensor/cnt=%b/%0d expected 1/0", sensor, vehicle_cnt);
        end
      end
    end
    n_checks++;
    if (sensor !== 1'b1 || stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_before_reset: sensor/stuck=%b/%b expected 1/0", sensor, stuck);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (sensor !== 1'b0 || stuck !== 1'b0 || vehicle_cnt !== '0) begin
      n_fail++;
      $display("FAIL async_reset: sensor/stuck/cnt=%b/%b/%0d expected 0/0/0",
               sensor, stuck, vehicle_cnt);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (sensor !== 1'b0 || vehicle_cnt !== CW'(m_cnt) || stuck !== exp_stuck) begin
        n_fail++;
        $display("FAIL reset_no_hold step %0d: sensor/stuck/cnt=%b/%b/%0d expected 0/%b/%0d",
                 i, sensor, stuck, vehicle_cnt, exp_stuck, m_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic v = 1'b0;
    int   len;
    for (int s = 0; s < 40; s++) begin
      v   = ~v;
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) begin
        step(v, $urandom_range(0, 19) == 0);
        n_checks++;
        if (sensor !== exp_sensor || stuck !== exp_stuck || vehicle_cnt !== CW'(m_cnt)) begin
          n_fail++;
          $display("FAIL random seg %0d step %0d: sensor/stuck/cnt=%b/%b/%0d expected %b/%b/%0d",
                   s, i, sensor, stuck, vehicle_cnt, exp_sensor, exp_stuck, m_cnt);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_glitch();
    test_clean_vehicle();
    test_back_to_back();
    test_stuck();
    test_saturation();
    test_clear_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
